// File: rtl/vai_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vai_pkg
//  Description : Shared types for the VAI Tx auditor. Provides a compact
//                CCI-P style Tx/Rx channel description, the auditor state
//                enum, request/response type codes and decode helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package vai_pkg;

  localparam int VAI_CL_ADDR_W = 42;
  localparam int VAI_DATA_W    = 512;
  localparam int VAI_MMIO_W    = 64;
  localparam int VAI_MDATA_W   = 16;
  localparam int VAI_TID_W     = 9;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HELD  = 2'd2
  } t_vai_audit_state;

  // c0 request types
  localparam logic [3:0] REQ_RDLINE_I = 4'h0;
  localparam logic [3:0] REQ_RDLINE_S = 4'h1;
  // c1 request types
  localparam logic [3:0] REQ_WRLINE_I = 4'h0;
  localparam logic [3:0] REQ_WRLINE_M = 4'h1;
  localparam logic [3:0] REQ_WRPUSH_I = 4'h2;
  localparam logic [3:0] REQ_WRFENCE  = 4'h4;
  // c0 response types
  localparam logic [3:0] RSP_RDLINE   = 4'h0;
  localparam logic [3:0] RSP_UMSG     = 4'h4;
  // c1 response types
  localparam logic [3:0] RSP_WRLINE   = 4'h0;
  localparam logic [3:0] RSP_WRFENCE  = 4'h4;

  typedef struct packed {
    logic [1:0]               vc_sel;
    logic [1:0]               cl_len;
    logic [3:0]               req_type;
    logic [VAI_CL_ADDR_W-1:0] address;
    logic [VAI_MDATA_W-1:0]   mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [1:0]               vc_sel;
    logic                     sop;
    logic [1:0]               cl_len;
    logic [3:0]               req_type;
    logic [VAI_CL_ADDR_W-1:0] address;
    logic [VAI_MDATA_W-1:0]   mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    logic [VAI_TID_W-1:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr    hdr;
    logic [VAI_DATA_W-1:0] data;
    logic                  valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr   hdr;
    logic                  mmioRdValid;
    logic [VAI_MMIO_W-1:0] data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  typedef struct packed {
    logic [3:0]             resp_type;
    logic [1:0]             cl_num;
    logic [VAI_MDATA_W-1:0] mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    logic [3:0]             resp_type;
    logic                   format;
    logic [1:0]             cl_num;
    logic [VAI_MDATA_W-1:0] mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  // A c0 response retires a read line only when it carries read data.
  function automatic logic vai_is_rd_rsp(input logic [3:0] resp_type);
    return resp_type == RSP_RDLINE;
  endfunction

  function automatic logic vai_is_wr_fence(input logic [3:0] req_type);
    return req_type == REQ_WRFENCE;
  endfunction

  // A packed write response acknowledges cl_num+1 lines at once.
  function automatic logic [2:0] vai_wr_rsp_lines(input t_ccip_c1_RspMemHdr hdr);
    return hdr.format ? ({1'b0, hdr.cl_num} + 3'd1) : 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vai_outstanding_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : vai_outstanding_ctr
//  Description : Outstanding-line counter. Applies a same-cycle increment and
//                decrement as one net update, clamps at zero (raising a
//                sticky underflow flag) and saturates at all-ones.
//  Ports       : clk, reset (sync, active-high), inc, dec (line amounts),
//                count (current lines outstanding), underflow (sticky)
//  Revision    : 1.0  initial release
// ============================================================================
module vai_outstanding_ctr #(
  parameter int CNT_W = 10,
  parameter int AMT_W = 3      // must not exceed CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AMT_W-1:0] inc,
  input  logic [AMT_W-1:0] dec,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  localparam int SUM_W = CNT_W + 1;

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] dec_ext;
  logic [SUM_W-1:0] diff;
  logic [SUM_W-1:0] max_ext;

  // One extra bit holds count+inc without wrapping.
  assign sum     = {1'b0, count} + SUM_W'(inc);
  assign dec_ext = SUM_W'(dec);
  assign diff    = sum - dec_ext;
  assign max_ext = {1'b0, {CNT_W{1'b1}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      underflow <= 1'b0;
    end else if (sum < dec_ext) begin
      count     <= '0;
      underflow <= 1'b1;
    end else if (diff > max_ext) begin
      count     <= '1;
    end else begin
      count     <= diff[CNT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/vai_tx_auditor.sv
`default_nettype none
// ============================================================================
//  Module      : vai_tx_auditor
//  Description : Per-VM Tx auditor between a sub-AFU and the Tx mux.
//                Relocates c0/c1 request addresses by the VM cache-line
//                offset (2-cycle pipeline), tracks outstanding read/write
//                lines from the Rx stream, and sequences a clean per-VM
//                reset: RUN -> DRAIN (block + drain) -> HELD -> RUN.
//  Config      : `VAI_AUDIT_BOUNDS_EN enables the guest-address bounds check
//                (out-of-range requests dropped and counted in viol_cnt);
//                otherwise viol_cnt is tied to zero.
//  Ports       : clk, reset (sync, active-high)
//                offset       VM base in cache lines, [41:0] used
//                vm_reset_req level reset request from the VAI manager
//                afu_tx       requests from the sub-AFU
//                mux_tx       relocated requests to the mux
//                mux_rx       responses for this VM (monitored only)
//                afu_reset    reset to the sub-AFU
//                drain_done   high while HELD
//                rsp_underflow sticky, response with nothing outstanding
//                viol_cnt     saturating count of bounds violations
//  Revision    : 1.0  initial release
// ============================================================================
module vai_tx_auditor
  import vai_pkg::*;
#(
  parameter int                       VMID     = 0,
  parameter int                       CNT_W    = 10,
  parameter logic [VAI_CL_ADDR_W-1:0] LIMIT_CL = 42'h0000_0100_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  offset,
  input  logic         vm_reset_req,
  input  t_if_ccip_Tx  afu_tx,
  output t_if_ccip_Tx  mux_tx,
  input  t_if_ccip_Rx  mux_rx,
  output logic         afu_reset,
  output logic         drain_done,
  output logic         rsp_underflow,
  output logic [31:0]  viol_cnt
);

  t_vai_audit_state         state;
  t_vai_audit_state         state_next;
  t_if_ccip_Tx              t1_tx;
  t_if_ccip_Tx              t2_next;
  t_if_ccip_Tx              t2_tx;
  logic [VAI_CL_ADDR_W-1:0] t1_offset;
  logic                     accept;
  logic                     c0_viol;
  logic                     c1_viol;
  logic                     pipe_empty;
  logic [2:0]               rd_inc;
  logic [2:0]               rd_dec;
  logic [2:0]               wr_inc;
  logic [2:0]               wr_dec;
  logic [CNT_W-1:0]         rd_out;
  logic [CNT_W-1:0]         wr_out;
  logic                     rd_uf;
  logic                     wr_uf;
  logic                     unused_ok;

  // New requests are admitted only while running.
  assign accept = (state == RUN);

  // --------------------------------------------------------------------------
  // Optional bounds check on the guest (pre-relocation) address
  // --------------------------------------------------------------------------
`ifdef VAI_AUDIT_BOUNDS_EN
  logic [VAI_CL_ADDR_W:0] c0_last_cl;
  logic [VAI_CL_ADDR_W:0] c1_last_cl;
  logic [1:0]             viol_inc;
  logic [32:0]            viol_sum;
  logic [31:0]            viol_cnt_r;

  assign c0_last_cl = {1'b0, afu_tx.c0.hdr.address} + {{(VAI_CL_ADDR_W-1){1'b0}}, afu_tx.c0.hdr.cl_len};
  assign c1_last_cl = {1'b0, afu_tx.c1.hdr.address} + {{(VAI_CL_ADDR_W-1){1'b0}}, afu_tx.c1.hdr.cl_len};

  assign c0_viol = afu_tx.c0.valid && (c0_last_cl >= {1'b0, LIMIT_CL});
  assign c1_viol = afu_tx.c1.valid && !vai_is_wr_fence(afu_tx.c1.hdr.req_type)
                   && (c1_last_cl >= {1'b0, LIMIT_CL});

  // Requests dropped by DRAIN never reach the check, so only RUN counts.
  assign viol_inc = {1'b0, c0_viol & accept} + {1'b0, c1_viol & accept};
  assign viol_sum = {1'b0, viol_cnt_r} + 33'(viol_inc);

  always_ff @(posedge clk) begin
    if (reset) begin
      viol_cnt_r <= '0;
    end else begin
      viol_cnt_r <= viol_sum[32] ? 32'hFFFF_FFFF : viol_sum[31:0];
    end
  end

  assign viol_cnt = viol_cnt_r;
`else
  assign c0_viol  = 1'b0;
  assign c1_viol  = 1'b0;
  assign viol_cnt = '0;
`endif

  // --------------------------------------------------------------------------
  // T1: capture request and the offset in force when it entered
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    t1_tx                <= afu_tx;
    t1_offset            <= offset[VAI_CL_ADDR_W-1:0];
    t1_tx.c0.valid       <= afu_tx.c0.valid && accept && !c0_viol;
    t1_tx.c1.valid       <= afu_tx.c1.valid && accept && !c1_viol;
    t1_tx.c2.mmioRdValid <= afu_tx.c2.mmioRdValid;
    if (reset) begin
      t1_tx.c0.valid       <= 1'b0;
      t1_tx.c1.valid       <= 1'b0;
      t1_tx.c2.mmioRdValid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // T2: relocate (mod 2^42 by natural wrap) and drive the mux
  // --------------------------------------------------------------------------
  always_comb begin
    t2_next                = t1_tx;
    t2_next.c0.hdr.address = t1_tx.c0.hdr.address + t1_offset;
    // A fence carries no address to relocate.
    if (!vai_is_wr_fence(t1_tx.c1.hdr.req_type)) begin
      t2_next.c1.hdr.address = t1_tx.c1.hdr.address + t1_offset;
    end
  end

  always_ff @(posedge clk) begin
    t2_tx <= t2_next;
    if (reset) begin
      t2_tx.c0.valid       <= 1'b0;
      t2_tx.c1.valid       <= 1'b0;
      t2_tx.c2.mmioRdValid <= 1'b0;
    end
  end

  assign mux_tx = t2_tx;

  // --------------------------------------------------------------------------
  // Outstanding line tracking; increments land with the T2 emission
  // --------------------------------------------------------------------------
  assign rd_inc = t1_tx.c0.valid ? ({1'b0, t1_tx.c0.hdr.cl_len} + 3'd1) : 3'd0;
  assign rd_dec = (mux_rx.c0.rspValid && vai_is_rd_rsp(mux_rx.c0.hdr.resp_type)) ? 3'd1 : 3'd0;
  assign wr_inc = {2'b00, t1_tx.c1.valid};
  assign wr_dec = mux_rx.c1.rspValid ? vai_wr_rsp_lines(mux_rx.c1.hdr) : 3'd0;

  vai_outstanding_ctr #(
    .CNT_W (CNT_W),
    .AMT_W (3)
  ) u_rd_ctr (
    .clk       (clk),
    .reset     (reset),
    .inc       (rd_inc),
    .dec       (rd_dec),
    .count     (rd_out),
    .underflow (rd_uf)
  );

  vai_outstanding_ctr #(
    .CNT_W (CNT_W),
    .AMT_W (3)
  ) u_wr_ctr (
    .clk       (clk),
    .reset     (reset),
    .inc       (wr_inc),
    .dec       (wr_dec),
    .count     (wr_out),
    .underflow (wr_uf)
  );

  assign rsp_underflow = rd_uf | wr_uf;

  // --------------------------------------------------------------------------
  // Reset sequencing FSM
  // --------------------------------------------------------------------------
  // MMIO responses never hold off the drain; only memory traffic does.
  assign pipe_empty = !t1_tx.c0.valid && !t1_tx.c1.valid
                      && !t2_tx.c0.valid && !t2_tx.c1.valid;

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (vm_reset_req) state_next = DRAIN;
      DRAIN:   if ((rd_out == '0) && (wr_out == '0) && pipe_empty) state_next = HELD;
      HELD:    if (!vm_reset_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // afu_reset is registered from the next state so it rises together with
  // DRAIN and falls together with the return to RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      afu_reset <= 1'b1;
    end else begin
      state     <= state_next;
      afu_reset <= (state_next != RUN);
    end
  end

  assign drain_done = (state == HELD);

  // Inputs and parameters carried for interface completeness only.
  assign unused_ok = ^{32'(VMID), LIMIT_CL, offset[63:VAI_CL_ADDR_W],
                       mux_rx.c0.hdr.cl_num, mux_rx.c0.hdr.mdata,
                       mux_rx.c1.hdr.resp_type, mux_rx.c1.hdr.mdata};

endmodule
`default_nettype wire

// File: tb/tb_vai_tx_auditor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vai_tx_auditor
//  Description : Self-checking bench for vai_tx_auditor. Directed scenarios
//                followed by randomized traffic, all compared every cycle
//                against a transaction-level reference model.
//  Config      : honours `VAI_AUDIT_BOUNDS_EN like the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vai_tx_auditor;
  import vai_pkg::*;

  localparam int          CNT_W    = 10;
  localparam logic [41:0] TB_LIMIT = 42'h100;
  localparam longint      CNT_MAX  = (64'd1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] offset;
  logic        vm_reset_req;
  t_if_ccip_Tx afu_tx;
  t_if_ccip_Tx mux_tx;
  t_if_ccip_Rx mux_rx;
  logic        afu_reset;
  logic        drain_done;
  logic        rsp_underflow;
  logic [31:0] viol_cnt;

  always #5 clk = ~clk;

  vai_tx_auditor #(
    .VMID     (3),
    .CNT_W    (CNT_W),
    .LIMIT_CL (TB_LIMIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .offset        (offset),
    .vm_reset_req  (vm_reset_req),
    .afu_tx        (afu_tx),
    .mux_tx        (mux_tx),
    .mux_rx        (mux_rx),
    .afu_reset     (afu_reset),
    .drain_done    (drain_done),
    .rsp_underflow (rsp_underflow),
    .viol_cnt      (viol_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Payload of an idle channel is don't-care.
  function automatic t_if_ccip_Tx mask_tx(input t_if_ccip_Tx t);
    mask_tx = t;
    if (!t.c0.valid)       mask_tx.c0 = '0;
    if (!t.c1.valid)       mask_tx.c1 = '0;
    if (!t.c2.mmioRdValid) mask_tx.c2 = '0;
  endfunction

  function automatic bit out_of_bounds(input logic [41:0] a, input logic [1:0] len);
`ifdef VAI_AUDIT_BOUNDS_EN
    return (longint'(a) + longint'(len)) >= longint'(TB_LIMIT);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- reference model ----------------
  // m_state: 0 running, 1 draining, 2 held
  int          m_state;
  longint      m_rd, m_wr, m_viol;
  bit          m_uf, m_afu_reset;
  t_if_ccip_Tx m_pend;   // accepted last edge, appears after the next one
  t_if_ccip_Tx m_out;    // what mux_tx must show now

  task automatic model_edge();
    t_if_ccip_Tx nxt;
    longint rd_n, wr_n;
    int     ns;
    bit     busy;
    if (reset) begin
      m_state = 0; m_rd = 0; m_wr = 0; m_viol = 0; m_uf = 0;
      m_afu_reset = 1; m_pend = '0; m_out = '0;
      return;
    end
    busy = m_pend.c0.valid || m_pend.c1.valid || m_out.c0.valid || m_out.c1.valid;
    rd_n = m_rd + (m_pend.c0.valid ? longint'(m_pend.c0.hdr.cl_len) + 1 : 0)
                - ((mux_rx.c0.rspValid && mux_rx.c0.hdr.resp_type == RSP_RDLINE) ? 1 : 0);
    wr_n = m_wr + (m_pend.c1.valid ? 1 : 0)
                - (mux_rx.c1.rspValid ? (mux_rx.c1.hdr.format ? longint'(mux_rx.c1.hdr.cl_num) + 1 : 1) : 0);
    if (rd_n < 0) begin rd_n = 0; m_uf = 1; end
    if (wr_n < 0) begin wr_n = 0; m_uf = 1; end
    if (rd_n > CNT_MAX) rd_n = CNT_MAX;
    if (wr_n > CNT_MAX) wr_n = CNT_MAX;
    ns = m_state;
    case (m_state)
      0: if (vm_reset_req) ns = 1;
      1: if (m_rd == 0 && m_wr == 0 && !busy) ns = 2;
      default: if (!vm_reset_req) ns = 0;
    endcase
    nxt = afu_tx;
    nxt.c0.hdr.address = afu_tx.c0.hdr.address + offset[41:0];
    if (afu_tx.c1.hdr.req_type != REQ_WRFENCE)
      nxt.c1.hdr.address = afu_tx.c1.hdr.address + offset[41:0];
    nxt.c0.valid = 0;
    nxt.c1.valid = 0;
    if (afu_tx.c0.valid && m_state == 0) begin
      if (out_of_bounds(afu_tx.c0.hdr.address, afu_tx.c0.hdr.cl_len)) m_viol++;
      else nxt.c0.valid = 1;
    end
    if (afu_tx.c1.valid && m_state == 0) begin
      if (afu_tx.c1.hdr.req_type != REQ_WRFENCE &&
          out_of_bounds(afu_tx.c1.hdr.address, afu_tx.c1.hdr.cl_len)) m_viol++;
      else nxt.c1.valid = 1;
    end
    if (m_viol > 64'hFFFF_FFFF) m_viol = 64'hFFFF_FFFF;
    m_out = m_pend;
    m_pend = nxt;
    m_rd = rd_n;
    m_wr = wr_n;
    m_state = ns;
    m_afu_reset = (ns != 0);
  endtask

  task automatic compare_all();
    check("mux_tx", mask_tx(mux_tx), mask_tx(m_out));
    check("afu_reset", afu_reset, m_afu_reset);
    check("drain_done", drain_done, m_state == 2);
    check("rsp_underflow", rsp_underflow, m_uf);
    check("viol_cnt", viol_cnt, m_viol);
    check("rd_out", dut.rd_out, m_rd);
    check("wr_out", dut.wr_out, m_wr);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle();
    afu_tx = '0;
    mux_rx = '0;
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drive_rd(input logic [41:0] a, input logic [1:0] len, input logic [15:0] md);
    afu_tx.c0.valid        = 1;
    afu_tx.c0.hdr.req_type = REQ_RDLINE_I;
    afu_tx.c0.hdr.address  = a;
    afu_tx.c0.hdr.cl_len   = len;
    afu_tx.c0.hdr.mdata    = md;
  endtask

  task automatic drive_wr(input logic [41:0] a);
    afu_tx.c1.valid        = 1;
    afu_tx.c1.hdr.req_type = REQ_WRLINE_I;
    afu_tx.c1.hdr.address  = a;
    afu_tx.c1.hdr.sop      = 1;
    afu_tx.c1.data         = {16{32'hA5A5_0000 | 32'(a[15:0])}};
  endtask

  task automatic rd_rsp();
    idle();
    mux_rx.c0.rspValid       = 1;
    mux_rx.c0.hdr.resp_type  = RSP_RDLINE;
    cycle();
  endtask

  task automatic wr_rsp();
    idle();
    mux_rx.c1.rspValid       = 1;
    mux_rx.c1.hdr.resp_type  = RSP_WRLINE;
    cycle();
  endtask

  task automatic randomize_inputs();
    afu_tx = '0;
    mux_rx = '0;
    if ($urandom_range(0, 99) < 5) offset = {$urandom, $urandom};
    if ($urandom_range(0, 39) == 0) vm_reset_req = ~vm_reset_req;
    if ($urandom_range(0, 99) < 35) begin
      afu_tx.c0.valid        = 1;
      afu_tx.c0.hdr.req_type = $urandom_range(0, 1) ? REQ_RDLINE_S : REQ_RDLINE_I;
      afu_tx.c0.hdr.cl_len   = 2'($urandom_range(0, 3));
      afu_tx.c0.hdr.vc_sel   = 2'($urandom);
      afu_tx.c0.hdr.mdata    = 16'($urandom);
      afu_tx.c0.hdr.address  = $urandom_range(0, 1) ? 42'($urandom_range(0, 'h110)) : 42'({$urandom, $urandom});
    end
    if ($urandom_range(0, 99) < 35) begin
      logic [3:0] types [4];
      types = '{REQ_WRLINE_I, REQ_WRLINE_M, REQ_WRPUSH_I, REQ_WRFENCE};
      afu_tx.c1.valid        = 1;
      afu_tx.c1.hdr.req_type = types[$urandom_range(0, 3)];
      afu_tx.c1.hdr.cl_len   = 2'($urandom_range(0, 3));
      afu_tx.c1.hdr.sop      = 1'($urandom);
      afu_tx.c1.hdr.mdata    = 16'($urandom);
      afu_tx.c1.hdr.address  = $urandom_range(0, 1) ? 42'($urandom_range(0, 'h110)) : 42'({$urandom, $urandom});
      for (int w = 0; w < 16; w++) afu_tx.c1.data[w*32 +: 32] = $urandom;
    end
    if ($urandom_range(0, 99) < 10) begin
      afu_tx.c2.mmioRdValid = 1;
      afu_tx.c2.hdr.tid     = 9'($urandom);
      afu_tx.c2.data        = {$urandom, $urandom};
    end
    if (m_rd > 0 && $urandom_range(0, 99) < 40) begin
      mux_rx.c0.rspValid      = 1;
      mux_rx.c0.hdr.resp_type = RSP_RDLINE;
      mux_rx.c0.hdr.mdata     = 16'($urandom);
    end else if ($urandom_range(0, 99) < 5) begin
      mux_rx.c0.rspValid      = 1;
      mux_rx.c0.hdr.resp_type = RSP_UMSG;
    end
    if (m_wr > 0 && $urandom_range(0, 99) < 40) begin
      mux_rx.c1.rspValid      = 1;
      mux_rx.c1.hdr.resp_type = RSP_WRLINE;
      mux_rx.c1.hdr.format    = 1'($urandom);
      mux_rx.c1.hdr.cl_num    = 2'($urandom_range(0, (m_wr > 4) ? 3 : int'(m_wr) - 1));
    end
  endtask

  initial begin
    reset = 1; vm_reset_req = 0; offset = '0;
    idle();
    idle_cycles(3);
    reset = 0;
    idle_cycles(2);

    // 1: read relocation, exact 2-cycle latency
    offset = 64'h1000;
    drive_rd(42'h20, 2'd0, 16'hABCD);
    cycle();
    idle_cycles(1);
    check("t1_addr", mux_tx.c0.hdr.address, 42'h1020);
    check("t1_mdata", mux_tx.c0.hdr.mdata, 16'hABCD);
    check("t1_valid", mux_tx.c0.valid, 1'b1);
    rd_rsp();
    idle_cycles(1);

    // 2: write address wraps modulo 2^42
    offset = 64'h3FF_FFFF_FFFF;
    drive_wr(42'h2);
    cycle();
    idle_cycles(1);
    check("t2_addr", mux_tx.c1.hdr.address, 42'h1);
    idle_cycles(2);
    check("t2_wr_out", dut.wr_out, 1);
    wr_rsp();
    check("t2_wr_zero", dut.wr_out, 0);

    // 3: drain waits for all four lines of a read
    offset = 64'h40;
    drive_rd(42'h10, 2'd3, 16'h0003);
    cycle();
    idle();
    vm_reset_req = 1;
    cycle();
    check("t3_afu_reset", afu_reset, 1'b1);
    idle_cycles(2);
    for (int i = 0; i < 4; i++) begin
      check("t3_not_done", drain_done, 1'b0);
      rd_rsp();
      idle_cycles(1);
    end
    idle_cycles(1);
    check("t3_done", drain_done, 1'b1);
    vm_reset_req = 0;
    idle_cycles(3);
    check("t3_released", afu_reset, 1'b0);

    // 4: write in flight at the request edge is emitted, later beats dropped
    drive_wr(42'h30);
    vm_reset_req = 1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      idle();
      drive_wr(42'h40 + 42'(i));
      cycle();
    end
    check("t4_wr_out", dut.wr_out, 1);
    check("t4_viol", viol_cnt, 32'd0);
    vm_reset_req = 0;      // falling mid-drain must not abort
    idle_cycles(2);
    wr_rsp();
    idle_cycles(4);

    // 5: response with nothing outstanding
    wr_rsp();
    idle_cycles(1);
    check("t5_uf", rsp_underflow, 1'b1);
    check("t5_wr", dut.wr_out, 0);

    // reset in the middle of a drain
    drive_rd(42'h50, 2'd1, 16'h0005);
    cycle();
    vm_reset_req = 1;
    idle_cycles(4);
    reset = 1;
    idle_cycles(1);
    reset = 0;
    vm_reset_req = 0;
    idle_cycles(2);
    check("rst_rd", dut.rd_out, 0);

`ifdef VAI_AUDIT_BOUNDS_EN
    // 6: bounds limit at 0x100 lines
    offset = '0;
    drive_rd(42'hFE, 2'd1, 16'h0006);
    cycle();
    idle();
    drive_rd(42'hFF, 2'd1, 16'h0007);
    cycle();
    idle_cycles(3);
    check("t6_viol", viol_cnt, 32'd1);
    check("t6_rd", dut.rd_out, 2);
    rd_rsp();
    rd_rsp();
    idle_cycles(2);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      cycle();
    end
    vm_reset_req = 0;
    idle_cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
